// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state encoding, UART MMIO addresses and status bit layout
// U_* states exist only when UART_MMIO_EN is defined.
package mem_pkg;

  localparam logic [15:0] UART_DATA_ADDR_DEF = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR_DEF = 16'hBF01;

  localparam int STAT_TX_RDY = 0;
  localparam int STAT_RX_RDY = 1;

  typedef enum logic [3:0] {
    IDLE,
    RD,
    WR1,
    WR2,
    WR3,
    DONE
`ifdef UART_MMIO_EN
    ,
    U_RD_WAIT,
    U_RD1,
    U_RD2,
    U_WR_WAIT,
    U_WR
`endif
  } state_t;

endpackage

// File: rtl/uart_if.sv
// rtl/uart_if.sv - UART strobe sequencer sharing the SRAM data bus (built only with UART_MMIO_EN)
// Waits for rx/tx readiness, drives the active-low strobes and returns a done pulse plus the byte.
`ifdef UART_MMIO_EN
module uart_if
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_rd,
  input  logic        start_wr,
  input  logic        data_ready,
  input  logic        tx_ready,
  input  logic [7:0]  bus_in,
  input  logic [7:0]  wr_byte,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rd_byte,
  output logic        drive_en,
  output logic [15:0] drive_data,
  output logic        rdn,
  output logic        wrn
);

  state_t state, state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    rdn       = 1'b1;
    wrn       = 1'b1;
    drive_en  = 1'b0;
    case (state)
      IDLE: begin
        if (start_wr)      state_nxt = U_WR_WAIT;
        else if (start_rd) state_nxt = U_RD_WAIT;
      end
      U_RD_WAIT: if (data_ready) state_nxt = U_RD1;
      U_RD1: begin
        rdn       = 1'b0;
        state_nxt = U_RD2;
      end
      // byte is sampled off the bus on the edge leaving U_RD2
      U_RD2: begin
        rdn       = 1'b0;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      U_WR_WAIT: if (tx_ready) state_nxt = U_WR;
      U_WR: begin
        wrn       = 1'b0;
        drive_en  = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign rd_byte    = bus_in;
  assign drive_data = {8'h00, wr_byte};

endmodule
`endif

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - memory-stage controller: multi-cycle SRAM access with pipeline stall
// UART_MMIO_EN adds the memory-mapped UART data/status paths through uart_if.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int          RAM_AW         = 18,
  parameter logic [15:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
  parameter logic [15:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       address,
  input  logic [15:0]       write_data,
  output logic [15:0]       read_data,
  output logic              stall,
  output logic [RAM_AW-1:0] ram_addr,
  inout  wire  [15:0]       ram_data,
  output logic              ram_en_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic              uart_rdn,
  output logic              uart_wrn,
  input  logic              uart_data_ready,
  input  logic              uart_tbre,
  input  logic              uart_tsre
);

  state_t state, state_nxt;
  logic   drv_sram;
  logic   ld_sram;

  assign ram_addr = {{(RAM_AW-16){1'b0}}, address};

`ifdef UART_MMIO_EN
  logic        sel_data, sel_stat;
  logic        ld_stat;
  logic        u_start_rd, u_start_wr;
  logic        u_busy, u_done, u_drive;
  logic [7:0]  u_byte;
  logic [15:0] u_drive_data;
  logic [15:0] stat_word;

  assign sel_data = (address == UART_DATA_ADDR);
  assign sel_stat = (address == UART_STAT_ADDR);

  always_comb begin
    stat_word              = '0;
    stat_word[STAT_TX_RDY] = uart_tbre & uart_tsre;
    stat_word[STAT_RX_RDY] = uart_data_ready;
  end

  uart_if u_uart (
    .clk        (clk),
    .rst        (rst),
    .start_rd   (u_start_rd),
    .start_wr   (u_start_wr),
    .data_ready (uart_data_ready),
    .tx_ready   (uart_tbre & uart_tsre),
    .bus_in     (ram_data[7:0]),
    .wr_byte    (write_data[7:0]),
    .busy       (u_busy),
    .done       (u_done),
    .rd_byte    (u_byte),
    .drive_en   (u_drive),
    .drive_data (u_drive_data),
    .rdn        (uart_rdn),
    .wrn        (uart_wrn)
  );

  assign ram_en_n = u_busy;
  assign ram_data = drv_sram ? write_data : (u_drive ? u_drive_data : {16{1'bz}});
`else
  logic unused_uart;
  assign unused_uart = ^{uart_data_ready, uart_tbre, uart_tsre, UART_DATA_ADDR, UART_STAT_ADDR};

  assign ram_en_n = 1'b0;
  assign uart_rdn = 1'b1;
  assign uart_wrn = 1'b1;
  assign ram_data = drv_sram ? write_data : {16{1'bz}};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // During a UART access this FSM parks in U_RD_WAIT / U_WR_WAIT until uart_if reports done.
  always_comb begin
    state_nxt  = state;
    stall      = 1'b1;
    drv_sram   = 1'b0;
    ram_oe_n   = 1'b1;
    ram_we_n   = 1'b1;
    ld_sram    = 1'b0;
`ifdef UART_MMIO_EN
    ld_stat    = 1'b0;
    u_start_rd = 1'b0;
    u_start_wr = 1'b0;
`endif
    case (state)
      IDLE: begin
        stall = mem_read | mem_write;
`ifdef UART_MMIO_EN
        if (mem_write && sel_data) begin
          u_start_wr = 1'b1;
          state_nxt  = U_WR_WAIT;
        end else if (mem_write && sel_stat) begin
          state_nxt  = DONE;
        end else if (mem_read && sel_data) begin
          u_start_rd = 1'b1;
          state_nxt  = U_RD_WAIT;
        end else if (mem_read && sel_stat) begin
          ld_stat    = 1'b1;
          state_nxt  = DONE;
        end else
`endif
        if (mem_write)     state_nxt = WR1;
        else if (mem_read) state_nxt = RD;
      end
      RD: begin
        ram_oe_n  = 1'b0;
        ld_sram   = 1'b1;
        state_nxt = DONE;
      end
      // data straddles the single write-enable cycle for setup and hold
      WR1: begin
        drv_sram  = 1'b1;
        state_nxt = WR2;
      end
      WR2: begin
        drv_sram  = 1'b1;
        ram_we_n  = 1'b0;
        state_nxt = WR3;
      end
      WR3: begin
        drv_sram  = 1'b1;
        state_nxt = DONE;
      end
`ifdef UART_MMIO_EN
      U_RD_WAIT, U_WR_WAIT: if (u_done) state_nxt = DONE;
`endif
      DONE: begin
        stall     = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          read_data <= '0;
    else if (ld_sram) read_data <= ram_data;
`ifdef UART_MMIO_EN
    else if (ld_stat) read_data <= stat_word;
    else if (u_done && state == U_RD_WAIT) read_data <= {8'h00, u_byte};
`endif
  end

endmodule
